// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the OTTER 5-stage pipeline: per-stage enables,
// bubble controls, data-memory wait FSM with timeout, and performance counters.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_haz,
    input  logic             branch_raw_haz,
    input  logic             br_taken_ex,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt, wait_nxt;

    logic at_limit, freeze;
    logic timeout_hit, flush_inc;
    logic pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c;
    logic if_id_flush_c, id_ex_flush_c;

    assign at_limit = (state == DMEM_WAIT) && (wait_cnt == WAIT_LIMIT);
    assign freeze   = dmem_req && !dmem_ready && !at_limit;

    always_comb begin
        pc_we_c       = 1'b1;
        if_id_we_c    = 1'b1;
        id_ex_we_c    = 1'b1;
        ex_mem_we_c   = 1'b1;
        mem_wb_we_c   = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        next_state    = RUN;
        wait_nxt      = '0;
        timeout_hit   = 1'b0;
        flush_inc     = 1'b0;

        if (freeze) begin
            // Whole pipeline holds; EX keeps its branch so it is re-evaluated on release.
            pc_we_c     = 1'b0;
            if_id_we_c  = 1'b0;
            id_ex_we_c  = 1'b0;
            ex_mem_we_c = 1'b0;
            mem_wb_we_c = 1'b0;
            next_state  = DMEM_WAIT;
            wait_nxt    = wait_cnt + 8'd1;
        end else if (at_limit && !dmem_ready) begin
            timeout_hit = 1'b1;
        end else if (br_taken_ex) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            flush_inc     = 1'b1;
        end else if (load_use_haz || branch_raw_haz) begin
            pc_we_c       = 1'b0;
            if_id_we_c    = 1'b0;
            id_ex_flush_c = 1'b1;
        end else if (!imem_ready) begin
            pc_we_c       = 1'b0;
            if_id_flush_c = 1'b1;
            next_state    = IMEM_WAIT;
        end
    end

    assign pc_we       = rst_n & pc_we_c;
    assign if_id_we    = rst_n & if_id_we_c;
    assign id_ex_we    = rst_n & id_ex_we_c;
    assign ex_mem_we   = rst_n & ex_mem_we_c;
    assign mem_wb_we   = rst_n & mem_wb_we_c;
    assign if_id_flush = rst_n & if_id_flush_c;
    assign id_ex_flush = rst_n & id_ex_flush_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_nxt;
            mem_timeout <= timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance plus a TIMEOUT=4,
// CNT_W=2 instance sharing the same stimulus for timeout and saturation cases.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use_haz, branch_raw_haz, br_taken_ex;
    logic imem_ready, dmem_req, dmem_ready;

    logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we;
    logic        s_if_id_flush, s_id_ex_flush, s_mem_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_haz(load_use_haz), .branch_raw_haz(branch_raw_haz),
        .br_taken_ex(br_taken_ex), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .load_use_haz(load_use_haz), .branch_raw_haz(branch_raw_haz),
        .br_taken_ex(br_taken_ex), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(s_pc_we), .if_id_we(s_if_id_we), .id_ex_we(s_id_ex_we),
        .ex_mem_we(s_ex_mem_we), .mem_wb_we(s_mem_wb_we),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush),
        .mem_timeout(s_mem_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Packed {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    function automatic logic [6:0] ctl();
        return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};
    endfunction

    function automatic logic [6:0] ctl_s();
        return {s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we, s_if_id_flush, s_id_ex_flush};
    endfunction

    task automatic idle();
        load_use_haz = 0; branch_raw_haz = 0; br_taken_ex = 0;
        imem_ready = 1; dmem_req = 0; dmem_ready = 0;
    endtask

    // Advance one clock; returns 1 ns after the edge so inputs change away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 0;
        #12;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000000", ctl());
        end
        checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_regs: stall=%0d flush=%0d to=%b want 0 0 0",
                               stall_cnt, flush_cnt, mem_timeout);
        end
        apply_reset();
    endtask

    task automatic test_idle();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ctl() !== 7'b1111100) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL idle_ctl: %0d bad cycles want 0", bad);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++; $display("FAIL idle_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        load_use_haz = 1;
        #1;
        checks++;
        if (ctl() !== 7'b0011101) begin
            errors++; $display("FAIL load_use_ctl: got %b want 0011101", ctl());
        end
        tick();
        load_use_haz = 0;
        #1;
        checks++;
        if (ctl() !== 7'b1111100) begin
            errors++; $display("FAIL load_use_release: got %b want 1111100", ctl());
        end
        checks++;
        if (stall_cnt !== 32'd1) begin
            errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        end
        // Branch RAW hazard behaves identically
        branch_raw_haz = 1;
        #1;
        checks++;
        if (ctl() !== 7'b0011101) begin
            errors++; $display("FAIL raw_haz_ctl: got %b want 0011101", ctl());
        end
        tick();
        branch_raw_haz = 0;
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++; $display("FAIL raw_haz_stall_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        br_taken_ex = 1; load_use_haz = 1; imem_ready = 0;
        #1;
        checks++;
        if (ctl() !== 7'b1111111) begin
            errors++; $display("FAIL branch_ctl: got %b want 1111111", ctl());
        end
        tick();
        idle();
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL branch_cnts: flush=%0d stall=%0d want 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_imem_wait();
        apply_reset();
        imem_ready = 0;
        #1;
        checks++;
        if (ctl() !== 7'b0111110) begin
            errors++; $display("FAIL imem_wait_ctl: got %b want 0111110", ctl());
        end
        tick();
        #1;
        checks++;
        if (ctl() !== 7'b0111110) begin
            errors++; $display("FAIL imem_wait_ctl2: got %b want 0111110", ctl());
        end
        tick();
        imem_ready = 1;
        #1;
        checks++;
        if (ctl() !== 7'b1111100 || stall_cnt !== 32'd2) begin
            errors++; $display("FAIL imem_exit: ctl=%b stall=%0d want 1111100 2", ctl(), stall_cnt);
        end
    endtask

    task automatic test_dmem_wait();
        int bad = 0;
        int to_seen = 0;
        apply_reset();
        dmem_req = 1; dmem_ready = 0; br_taken_ex = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ctl() !== 7'b0000000) bad++;
            if (mem_timeout !== 1'b0 || s_mem_timeout !== 1'b0) to_seen++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL dmem_freeze_ctl: %0d bad cycles want 0", bad);
        end
        dmem_ready = 1; br_taken_ex = 0;
        #1;
        checks++;
        if (ctl() !== 7'b1111100) begin
            errors++; $display("FAIL dmem_release: got %b want 1111100", ctl());
        end
        tick();
        idle();
        #1;
        if (mem_timeout !== 1'b0 || s_mem_timeout !== 1'b0) to_seen++;
        checks++;
        if (stall_cnt !== 32'd3 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL dmem_cnts: stall=%0d flush=%0d want 3 0", stall_cnt, flush_cnt);
        end
        checks++;
        if (to_seen != 0) begin
            errors++; $display("FAIL dmem_no_timeout: %0d pulses want 0", to_seen);
        end
    endtask

    task automatic test_timeout4();
        int bad = 0;
        apply_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ctl_s() !== 7'b0000000 || s_mem_timeout !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL t4_freeze: %0d bad cycles want 0", bad);
        end
        #1;
        checks++;
        if (ctl_s() !== 7'b1111100 || s_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL t4_release: ctl=%b to=%b want 1111100 0", ctl_s(), s_mem_timeout);
        end
        tick();
        dmem_req = 0;
        #1;
        checks++;
        if (s_mem_timeout !== 1'b1 || ctl_s() !== 7'b1111100) begin
            errors++; $display("FAIL t4_pulse: to=%b ctl=%b want 1 1111100", s_mem_timeout, ctl_s());
        end
        tick();
        checks++;
        if (s_mem_timeout !== 1'b0) begin
            errors++; $display("FAIL t4_pulse_width: to=%b want 0", s_mem_timeout);
        end
        // Back in RUN: a fresh stuck access freezes again from a zero wait count
        dmem_req = 1;
        #1;
        checks++;
        if (ctl_s() !== 7'b0000000) begin
            errors++; $display("FAIL t4_refreeze: got %b want 0000000", ctl_s());
        end
        idle();
    endtask

    task automatic test_timeout16();
        int frozen = 0;
        int pulse_at = -1;
        apply_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) dmem_req = 0;
            #1;
            if (ctl() == 7'b0000000) frozen++;
            if (mem_timeout === 1'b1 && pulse_at < 0) pulse_at = i;
            tick();
        end
        checks++;
        if (frozen != 15 || pulse_at != 16) begin
            errors++; $display("FAIL t16: frozen=%0d pulse_at=%0d want 15 16", frozen, pulse_at);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        load_use_haz = 1; 
        for (int i = 0; i < 5; i++) tick();
        idle();
        checks++;
        if (s_stall_cnt !== 2'd3 || stall_cnt !== 32'd5) begin
            errors++; $display("FAIL stall_saturate: s=%0d main=%0d want 3 5", s_stall_cnt, stall_cnt);
        end
        br_taken_ex = 1;
        for (int i = 0; i < 4; i++) tick();
        idle();
        checks++;
        if (s_flush_cnt !== 2'd3 || flush_cnt !== 32'd4) begin
            errors++; $display("FAIL flush_saturate: s=%0d main=%0d want 3 4", s_flush_cnt, flush_cnt);
        end
    endtask

    task automatic test_reset_mid_wait();
        int to_seen = 0;
        apply_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++; $display("FAIL midwait_pre: stall=%0d want 5", stall_cnt);
        end
        dmem_ready = 1;
        rst_n = 0;
        #1;
        checks++;
        if (ctl() !== 7'b0000000 || stall_cnt !== 32'd0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL midwait_reset: ctl=%b stall=%0d to=%b want 0000000 0 0",
                               ctl(), stall_cnt, mem_timeout);
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_timeout !== 1'b0) to_seen++;
        end
        #1;
        checks++;
        if (ctl() !== 7'b1111100 || stall_cnt !== 32'd0 || to_seen != 0) begin
            errors++; $display("FAIL midwait_after: ctl=%b stall=%0d pulses=%0d want 1111100 0 0",
                               ctl(), stall_cnt, to_seen);
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_idle();
        test_load_use();
        test_branch();
        test_imem_wait();
        test_dmem_wait();
        test_timeout4();
        test_timeout16();
        test_saturate();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the OTTER 5-stage pipeline.
- Takes hazard flags from the hazard detection unit, branch resolution from EX, and ready signals from the instruction and data memories.
- Produces per-stage register write-enables and flush (bubble) controls.
- Holds a data-memory wait FSM with timeout, plus stall and flush performance counters.

Parameters:
- TIMEOUT, 16, max cycles spent in DMEM_WAIT before abort; legal range 2..255.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- load_use_haz  in  1  load-use hazard from hazard detection unit
- branch_raw_haz  in  1  branch RAW hazard from hazard detection unit
- br_taken_ex  in  1  branch/jump in EX resolved taken
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_req  in  1  MEM stage holds a load/store
- dmem_ready  in  1  data memory completes access this cycle
- pc_we  out  1  PC register update enable
- if_id_we  out  1  IF/ID register enable
- id_ex_we  out  1  ID/EX register enable
- ex_mem_we  out  1  EX/MEM register enable
- mem_wb_we  out  1  MEM/WB register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- mem_timeout  out  1  one-cycle pulse: dmem access aborted
- stall_cnt  out  CNT_W  cycles with pc_we=0
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
Reset and output timing:
- rst_n low (async): state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
- While rst_n is low, all *_we=0 and both flushes=0.
- Control outputs are combinational from state plus inputs (same-cycle response). mem_timeout and the counters are registered.

States:
- RUN, DMEM_WAIT, IMEM_WAIT.
- wait_cnt is 8 bits and counts cycles in DMEM_WAIT.

Priority, evaluated every cycle, first match wins:
1. Freeze, when dmem_req & ~dmem_ready and the timeout is not reached:
   - All five *_we=0, flushes=0.
   - Next state DMEM_WAIT; wait_cnt increments.
   - br_taken_ex and the hazard inputs are ignored; they are re-evaluated after release because EX holds its contents.
2. Timeout, when in DMEM_WAIT with wait_cnt==TIMEOUT-1 and ~dmem_ready:
   - mem_timeout=1 on the next cycle.
   - Pipeline released this cycle as in case 6 with ex_mem_we=1.
   - Next state RUN; wait_cnt=0.
3. Taken branch, when br_taken_ex:
   - pc_we=1, all *_we=1, if_id_flush=1, id_ex_flush=1.
   - flush_cnt++.
   - Overrides load_use_haz, branch_raw_haz and ~imem_ready; the wrong-path fetch is discarded.
4. Hazard stall, when load_use_haz | branch_raw_haz:
   - pc_we=0, if_id_we=0, id_ex_flush=1; id_ex_we, ex_mem_we, mem_wb_we=1.
   - Lasts as long as the input is asserted.
5. Fetch wait, when ~imem_ready:
   - pc_we=0, if_id_we=1, if_id_flush=1; the remaining stages advance.
   - Next state IMEM_WAIT.
6. Otherwise:
   - All *_we=1, flushes=0, next state RUN, wait_cnt=0.
   - Leaving DMEM_WAIT on dmem_ready resumes normally in the same cycle.

Other rules:
- IMEM_WAIT exits to RUN on the first cycle with imem_ready=1.
- Counters:
  - stall_cnt increments on every post-reset cycle with pc_we=0, including freezes.
  - Both counters saturate at all-ones; no wrap.
- A flush and a freeze never coexist; the freeze masks the flush.
- Reset asserted mid-DMEM_WAIT: immediate return to RUN, counters cleared, no mem_timeout pulse.

Test Plan:
- Reset, then all inputs idle with imem_ready=1 -> all *_we=1, flushes=0, stall_cnt=0 over 10 cycles.
- load_use_haz=1 for 1 cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all *_we=1; stall_cnt=1.
- br_taken_ex=1 together with load_use_haz=1 and imem_ready=0 -> pc_we=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1; stall_cnt unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 -> 3 cycles all *_we=0; on the 4th cycle all *_we=1; stall_cnt=3; no mem_timeout.
- TIMEOUT=4, dmem_req=1, dmem_ready held 0 -> 3 cycles frozen, release on the 4th, mem_timeout=1 for exactly the 5th cycle, state RUN.
- rst_n pulsed low during DMEM_WAIT with stall_cnt=5 -> outputs forced to 0 immediately; after release stall_cnt=0, state RUN, mem_timeout never asserted.
